lod_share_arbiter: RTL and testbench



---
 rtl/lod_share_arbiter_if.sv | 30 +++
 rtl/lod_share_arbiter.sv | 93 +++++++++
 tb/tb_lod_share_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lod_share_arbiter_if.sv
// Handshake bundle between two posit adder lanes, the shared LOD/normalise unit and its consumer.
interface lod_share_arbiter_if #(
   parameter int unsigned N  = 8,
   parameter int unsigned es = 4
);
   localparam int unsigned W = N - es + 4;

   logic         req0_valid;
   logic [W-1:0] req0_data;
   logic         req0_ready;
   logic         req1_valid;
   logic [W-1:0] req1_data;
   logic         req1_ready;
   logic         out_valid;
   logic         out_ready;
   logic         out_id;
   logic [N-1:0] out_count;
   logic         out_zero;
   logic [W-1:0] out_norm;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, out_ready,
      input  req0_ready, req1_ready, out_valid, out_id, out_count, out_zero, out_norm
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
      output req0_ready, req1_ready, out_valid, out_id, out_count, out_zero, out_norm
   );
endinterface

// File: rtl/lod_share_arbiter.sv
// Round-robin arbiter sharing one leading-one-detect/normalise datapath between two lanes.
// Two-stage pipeline: S1 holds the granted word, S2 holds the normalised result.
module lod_share_arbiter #(
   parameter int unsigned N  = 8,
   parameter int unsigned es = 4
) (
   input logic                clk,
   input logic                reset,
   lod_share_arbiter_if.slave bus
);
   localparam int unsigned W  = N - es + 4;
   localparam int unsigned CW = $clog2(W);

   logic         s1_v;
   logic         s1_id;
   logic [W-1:0] s1_data;
   logic         last_grant;

   logic         s2_load_c;
   logic         s1_free_c;
   logic         grant0_c;
   logic         grant1_c;
   logic [CW-1:0] count_c;
   logic [W-1:0]  norm_c;

   assign s2_load_c = s1_v && (!bus.out_valid || bus.out_ready);
   assign s1_free_c = !s1_v || s2_load_c;

   // Lone requester wins; on contention the lane opposite last_grant wins.
   always_comb begin
      grant0_c = 1'b0;
      grant1_c = 1'b0;
      if (!reset && s1_free_c) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant0_c = last_grant;
            grant1_c = !last_grant;
         end else begin
            grant0_c = bus.req0_valid;
            grant1_c = bus.req1_valid;
         end
      end
   end

   assign bus.req0_ready = grant0_c;
   assign bus.req1_ready = grant1_c;

   // Leading-zero count over bits W-1..1; bit 0 is never examined, so it saturates at W-1.
   always_comb begin
      logic found;
      found   = 1'b0;
      count_c = CW'(W - 1);
      for (int i = int'(W) - 1; i >= 1; i--) begin
         if (!found && s1_data[CW'(i)]) begin
            found   = 1'b1;
            count_c = CW'(int'(W) - 1 - i);
         end
      end
      norm_c = s1_data << count_c;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_v          <= 1'b0;
         s1_id         <= 1'b0;
         s1_data       <= '0;
         last_grant    <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out_id    <= 1'b0;
         bus.out_count <= '0;
         bus.out_zero  <= 1'b0;
         bus.out_norm  <= '0;
      end else begin
         if (s2_load_c) begin
            bus.out_valid <= 1'b1;
            bus.out_id    <= s1_id;
            bus.out_count <= N'(count_c);
            bus.out_zero  <= (s1_data == '0);
            bus.out_norm  <= norm_c;
         end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end

         if (grant0_c || grant1_c) begin
            s1_v       <= 1'b1;
            s1_id      <= grant1_c;
            s1_data    <= grant1_c ? bus.req1_data : bus.req0_data;
            last_grant <= grant1_c;
         end else if (s2_load_c) begin
            s1_v <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_lod_share_arbiter.sv
// Directed and randomised checks of lod_share_arbiter against hand-computed values and a queue scoreboard.
module tb_lod_share_arbiter;
   localparam int unsigned N  = 8;
   localparam int unsigned ES = 4;
   localparam int unsigned W  = N - ES + 4;

   typedef struct {
      logic         id;
      logic [W-1:0] data;
   } ent_t;

   logic clk;
   logic reset;
   int   checks = 0;
   int   passes = 0;
   ent_t sb[$];

   lod_share_arbiter_if #(.N(N), .es(ES)) bus ();
   lod_share_arbiter #(.N(N), .es(ES)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v0, input logic [W-1:0] d0, input logic v1,
                        input logic [W-1:0] d1, input logic rdy);
      bus.req0_valid = v0;
      bus.req0_data  = d0;
      bus.req1_valid = v1;
      bus.req1_data  = d1;
      bus.out_ready  = rdy;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      next_cycle();
      reset = 1'b0;
   endtask

   // Reference: shift left until the MSB is set, at most W-1 times.
   task automatic ref_lod(input logic [W-1:0] d, output logic [N-1:0] c, output logic [W-1:0] n);
      int k = 0;
      logic [W-1:0] t = d;
      while (k < int'(W) - 1 && !t[W-1]) begin
         t = t << 1;
         k++;
      end
      c = N'(k);
      n = t;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 8'h55, 1'b1, 8'h33, 1'b1);
      @(negedge clk);
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b00)
         $display("FAIL reset_ready: got %b want 00", {bus.req0_ready, bus.req1_ready});
      else passes++;
      next_cycle();
      reset = 1'b0;
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_id, bus.out_count, bus.out_zero, bus.out_norm} !== 19'h0)
         $display("FAIL reset_out: got v=%b id=%b c=%0d z=%b n=%h want all zero",
                  bus.out_valid, bus.out_id, bus.out_count, bus.out_zero, bus.out_norm);
      else passes++;
      next_cycle();
   endtask

   task automatic test_single();
      drive(1'b1, 8'b0001_0110, 1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
         $display("FAIL single_ready: got %b want 10", {bus.req0_ready, bus.req1_ready});
      else passes++;
      next_cycle();
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0)
         $display("FAIL single_early: out_valid got %b want 0", bus.out_valid);
      else passes++;
      next_cycle();
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_id, bus.out_count, bus.out_zero, bus.out_norm} !==
          {1'b1, 1'b0, 8'd3, 1'b0, 8'b1011_0000})
         $display("FAIL single_result: got v=%b id=%b c=%0d z=%b n=%h want v=1 id=0 c=3 z=0 n=b0",
                  bus.out_valid, bus.out_id, bus.out_count, bus.out_zero, bus.out_norm);
      else passes++;
      next_cycle();
   endtask

   task automatic test_boundary();
      logic [W-1:0] din [3];
      logic [N-1:0] ecnt[3];
      logic         ez  [3];
      logic [W-1:0] enrm[3];
      din  = '{8'h00, 8'h01, 8'h80};
      ecnt = '{8'd7, 8'd7, 8'd0};
      ez   = '{1'b1, 1'b0, 1'b0};
      enrm = '{8'h00, 8'h80, 8'h80};
      for (int i = 0; i < 5; i++) begin
         if (i < 3) drive(1'b0, '0, 1'b1, din[i], 1'b1);
         else drive(1'b0, '0, 1'b0, '0, 1'b1);
         @(negedge clk);
         if (i >= 2) begin
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_count, bus.out_zero, bus.out_norm} !==
                {1'b1, 1'b1, ecnt[i-2], ez[i-2], enrm[i-2]})
               $display("FAIL boundary_%h: got v=%b id=%b c=%0d z=%b n=%h want v=1 id=1 c=%0d z=%b n=%h",
                        din[i-2], bus.out_valid, bus.out_id, bus.out_count, bus.out_zero, bus.out_norm,
                        ecnt[i-2], ez[i-2], enrm[i-2]);
            else passes++;
         end
         next_cycle();
      end
   endtask

   task automatic test_contention();
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(1'b1, 8'h40, 1'b1, 8'h08, 1'b1);
         else drive(1'b0, '0, 1'b0, '0, 1'b1);
         @(negedge clk);
         if (i < 4) begin
            checks++;
            if ({bus.req0_ready, bus.req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
               $display("FAIL contention_grant%0d: got %b want %b", i,
                        {bus.req0_ready, bus.req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            else passes++;
         end
         if (i >= 2) begin
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_count, bus.out_norm} !==
                {1'b1, 1'(i % 2), ((i % 2 == 0) ? 8'd1 : 8'd4), 8'h80})
               $display("FAIL contention_out%0d: got v=%b id=%b c=%0d n=%h want v=1 id=%0d c=%0d n=80",
                        i - 2, bus.out_valid, bus.out_id, bus.out_count, bus.out_norm,
                        i % 2, (i % 2 == 0) ? 1 : 4);
            else passes++;
         end
         next_cycle();
      end
   endtask

   task automatic test_backpressure();
      logic [4:0] er0;
      logic [4:0] er1;
      er0 = 5'b00001;
      er1 = 5'b00010;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'h16, 1'b1, 8'h03, 1'b0);
         @(negedge clk);
         checks++;
         if ({bus.req0_ready, bus.req1_ready} !== {er0[i], er1[i]})
            $display("FAIL bp_ready%0d: got %b want %b", i,
                     {bus.req0_ready, bus.req1_ready}, {er0[i], er1[i]});
         else passes++;
         if (i >= 2) begin
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_count, bus.out_zero, bus.out_norm} !==
                {1'b1, 1'b0, 8'd3, 1'b0, 8'hb0})
               $display("FAIL bp_hold%0d: got v=%b id=%b c=%0d z=%b n=%h want v=1 id=0 c=3 z=0 n=b0",
                        i, bus.out_valid, bus.out_id, bus.out_count, bus.out_zero, bus.out_norm);
            else passes++;
         end
         next_cycle();
      end
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_id, bus.out_count} !== {1'b1, 1'b0, 8'd3})
         $display("FAIL bp_drain0: got v=%b id=%b c=%0d want v=1 id=0 c=3",
                  bus.out_valid, bus.out_id, bus.out_count);
      else passes++;
      next_cycle();
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_id, bus.out_count, bus.out_norm} !== {1'b1, 1'b1, 8'd6, 8'hc0})
         $display("FAIL bp_drain1: got v=%b id=%b c=%0d n=%h want v=1 id=1 c=6 n=c0",
                  bus.out_valid, bus.out_id, bus.out_count, bus.out_norm);
      else passes++;
      next_cycle();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0)
         $display("FAIL bp_empty: out_valid got %b want 0", bus.out_valid);
      else passes++;
      next_cycle();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      drive(1'b0, '0, 1'b1, 8'h01, 1'b0);
      next_cycle();
      drive(1'b1, 8'h16, 1'b0, '0, 1'b0);
      next_cycle();
      reset = 1'b1;
      drive(1'b1, 8'h16, 1'b1, 8'h01, 1'b0);
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.req0_ready, bus.req1_ready} !== 3'b100)
         $display("FAIL midrst_during: got v=%b rdy=%b want v=1 rdy=00",
                  bus.out_valid, {bus.req0_ready, bus.req1_ready});
      else passes++;
      next_cycle();
      reset = 1'b0;
      drive(1'b1, 8'h20, 1'b1, 8'h01, 1'b1);
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.req0_ready, bus.req1_ready} !== 3'b010)
         $display("FAIL midrst_after: got v=%b rdy=%b want v=0 rdy=10",
                  bus.out_valid, {bus.req0_ready, bus.req1_ready});
      else passes++;
      next_cycle();
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0)
         $display("FAIL midrst_flushed: out_valid got %b want 0", bus.out_valid);
      else passes++;
      next_cycle();
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_id, bus.out_count, bus.out_zero, bus.out_norm} !==
          {1'b1, 1'b0, 8'd2, 1'b0, 8'h80})
         $display("FAIL midrst_first: got v=%b id=%b c=%0d z=%b n=%h want v=1 id=0 c=2 z=0 n=80",
                  bus.out_valid, bus.out_id, bus.out_count, bus.out_zero, bus.out_norm);
      else passes++;
      next_cycle();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0)
         $display("FAIL midrst_empty: out_valid got %b want 0", bus.out_valid);
      else passes++;
      next_cycle();
   endtask

   task automatic check_output();
      ent_t         e;
      logic [N-1:0] c;
      logic [W-1:0] n;
      if (bus.out_valid && bus.out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            $display("FAIL rand_extra: result id=%b n=%h with no word outstanding", bus.out_id, bus.out_norm);
         end else begin
            e = sb.pop_front();
            ref_lod(e.data, c, n);
            if ({bus.out_id, bus.out_count, bus.out_zero, bus.out_norm} !== {e.id, c, (e.data == '0), n})
               $display("FAIL rand_result: word %h got id=%b c=%0d z=%b n=%h want id=%b c=%0d z=%b n=%h",
                        e.data, bus.out_id, bus.out_count, bus.out_zero, bus.out_norm,
                        e.id, c, (e.data == '0), n);
            else passes++;
         end
      end
   endtask

   task automatic test_random();
      logic         v0, v1, rdy;
      logic [W-1:0] d0, d1;
      logic         prev_hold = 1'b0;
      logic [1+N+1+W-1:0] prev_out = '0;
      int           wait0 = 0;
      int           wait1 = 0;
      apply_reset();
      sb.delete();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         v0  = ($urandom_range(0, 9) < 6);
         v1  = ($urandom_range(0, 9) < 6);
         rdy = ($urandom_range(0, 9) < 7);
         d0  = W'($urandom) >> $urandom_range(0, W);
         d1  = W'($urandom) >> $urandom_range(0, W);
         drive(v0, d0, v1, d1, rdy);
         @(negedge clk);
         checks++;
         if ((bus.req0_ready && !v0) || (bus.req1_ready && !v1) || (bus.req0_ready && bus.req1_ready))
            $display("FAIL rand_ready: cycle %0d rdy=%b valid=%b", cyc,
                     {bus.req0_ready, bus.req1_ready}, {v0, v1});
         else passes++;
         if (prev_hold) begin
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_count, bus.out_zero, bus.out_norm} !== {1'b1, prev_out})
               $display("FAIL rand_hold: cycle %0d got v=%b out=%h want v=1 out=%h", cyc, bus.out_valid,
                        {bus.out_id, bus.out_count, bus.out_zero, bus.out_norm}, prev_out);
            else passes++;
         end
         check_output();
         if (bus.req0_ready) sb.push_back('{id: 1'b0, data: d0});
         if (bus.req1_ready) sb.push_back('{id: 1'b1, data: d1});
         wait0 = (!v0 || bus.req0_ready) ? 0 : (bus.req1_ready ? wait0 + 1 : wait0);
         wait1 = (!v1 || bus.req1_ready) ? 0 : (bus.req0_ready ? wait1 + 1 : wait1);
         if (wait0 > 0 || wait1 > 0) begin
            checks++;
            if (wait0 > 2 || wait1 > 2)
               $display("FAIL rand_starve: cycle %0d waits %0d/%0d want <=2", cyc, wait0, wait1);
            else passes++;
         end
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_out  = {bus.out_id, bus.out_count, bus.out_zero, bus.out_norm};
         next_cycle();
      end
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, '0, 1'b0, '0, 1'b1);
         @(negedge clk);
         check_output();
         next_cycle();
      end
      checks++;
      if (sb.size() != 0 || bus.out_valid !== 1'b0)
         $display("FAIL rand_drain: %0d words undelivered, out_valid=%b want 0 and 0", sb.size(), bus.out_valid);
      else passes++;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      test_reset();
      test_single();
      test_boundary();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
